coin_acceptor: RTL

Coin-slot front end that drives the N/D coin interface of the vending machine controller. It synchronizes and debounces the two raw coin-sensor inputs and classifies each coin. It emits exactly one single-cycle N or D pulse per accepted coin, a reject pulse for invalid or inhibited coins, and a jam flag for stuck sensors. All outputs are Moore, decoded directly from one-hot state bits.

---
 rtl/coin_acceptor_pkg.sv | 32 +++
 rtl/coin_acceptor_sync_2ff.sv | 23 ++
 rtl/coin_acceptor.sv | 112 +++++++++++
 3 files changed

// File: rtl/coin_acceptor_pkg.sv
// rtl/coin_acceptor_pkg.sv - shared types and constants for the coin acceptor
package coin_acceptor_pkg;

  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    QUALIFY  = 7'b0000010,
    EMIT_N   = 7'b0000100,
    EMIT_D   = 7'b0001000,
    EMIT_REJ = 7'b0010000,
    CLEAR    = 7'b0100000,
    JAM      = 7'b1000000
  } state_t;

  // One-hot bit positions of the states that drive outputs directly
  localparam int ST_EMIT_N   = 2;
  localparam int ST_EMIT_D   = 3;
  localparam int ST_EMIT_REJ = 4;
  localparam int ST_JAM      = 6;

  localparam logic [1:0] PAT_NONE = 2'b00;
  localparam logic [1:0] PAT_N    = 2'b10;
  localparam logic [1:0] PAT_D    = 2'b01;
  localparam logic [1:0] PAT_BOTH = 2'b11;

  function automatic state_t emit_sel(input logic inh, input logic [1:0] pat);
    if (inh || pat == PAT_BOTH) return EMIT_REJ;
    else if (pat == PAT_N)      return EMIT_N;
    else if (pat == PAT_D)      return EMIT_D;
    else                        return EMIT_REJ;
  endfunction

endpackage

// File: rtl/coin_acceptor_sync_2ff.sv
// rtl/coin_acceptor_sync_2ff.sv - two-flop synchronizer for asynchronous sensor inputs
module sync_2ff #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounces coin sensors and emits N/D/reject pulses plus a jam flag
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_COIN_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic sense_n,
  input  logic sense_d,
  input  logic inhibit,
  output logic N,
  output logic D,
  output logic reject,
  output logic jam
);

  localparam int CW = $clog2(MAX_COIN_CYCLES + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COIN_CYCLES);

  state_t          state, state_nx;
  logic [1:0]      p, cand, cand_nx;
  logic [CW-1:0]   stab, stab_nx, dwell, dwell_nx, dwell_inc;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({sense_n, sense_d}),
    .q   (p)
  );

  assign dwell_inc = (dwell == MAX_C) ? dwell : dwell + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand  <= PAT_NONE;
      stab  <= '0;
      dwell <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      stab  <= stab_nx;
      dwell <= dwell_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    stab_nx  = stab;
    dwell_nx = dwell;
    case (state)
      IDLE: begin
        if (p != PAT_NONE) begin
          cand_nx  = p;
          stab_nx  = CW'(1);
          dwell_nx = '0;
          state_nx = (DEB_C == CW'(1)) ? emit_sel(inhibit, p) : QUALIFY;
        end
      end
      QUALIFY: begin
        dwell_nx = dwell_inc;
        // Dwell timeout wins over a coin that qualifies on the same edge
        if (dwell_inc == MAX_C) begin
          state_nx = JAM;
          stab_nx  = '0;
        end else if (p == cand) begin
          stab_nx = stab + CW'(1);
          if (stab_nx == DEB_C) state_nx = emit_sel(inhibit, cand);
        end else if (p == PAT_NONE) begin
          state_nx = IDLE;
        end else begin
          cand_nx = p;
          stab_nx = CW'(1);
        end
      end
      EMIT_N, EMIT_D, EMIT_REJ: begin
        state_nx = CLEAR;
        stab_nx  = '0;
        dwell_nx = '0;
      end
      CLEAR: begin
        if (p == PAT_NONE) begin
          stab_nx = stab + CW'(1);
        end else begin
          stab_nx  = '0;
          dwell_nx = dwell_inc;
        end
        if (dwell_nx == MAX_C) begin
          state_nx = JAM;
          stab_nx  = '0;
        end else if (stab_nx == DEB_C) begin
          state_nx = IDLE;
        end
      end
      JAM: begin
        stab_nx = (p == PAT_NONE) ? stab + CW'(1) : '0;
        if (stab_nx == DEB_C) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign N      = state[ST_EMIT_N];
  assign D      = state[ST_EMIT_D];
  assign reject = state[ST_EMIT_REJ];
  assign jam    = state[ST_JAM];

endmodule
